// File: rtl/exec_stage.sv
// rtl/exec_stage.sv - execute stage: operand select, 32-bit ALU, 2-entry skid-buffered result output
module exec_stage #(
    parameter int W  = 32,
    parameter int RA = 5
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          In_Valid,
    output logic          In_Ready,
    input  logic [W-1:0]  A,
    input  logic [W-1:0]  B,
    input  logic [W-1:0]  Imm,
    input  logic          ALUsrc,
    input  logic [3:0]    Op,
    input  logic [RA-1:0] Rd,
    input  logic          RegWrite,
    input  logic          Flush,
    output logic          Out_Valid,
    input  logic          Out_Ready,
    output logic [W-1:0]  Out_Res,
    output logic          Out_Zero,
    output logic [RA-1:0] Out_Rd,
    output logic          Out_RegWrite,
    output logic [31:0]   Retired
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_NOT = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_SLL = 4'b1001;
    localparam logic [3:0] OP_SRL = 4'b1010;
    localparam logic [3:0] OP_ROL = 4'b1100;
    localparam logic [3:0] OP_ROR = 4'b1101;

    // Output register (stage 0)
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_res_q,   out_res_d;
    logic          out_zero_q,  out_zero_d;
    logic [RA-1:0] out_rd_q,    out_rd_d;
    logic          out_rw_q,    out_rw_d;

    // Skid entry (stage 1)
    logic          skid_valid_q, skid_valid_d;
    logic [W-1:0]  skid_res_q,   skid_res_d;
    logic          skid_zero_q,  skid_zero_d;
    logic [RA-1:0] skid_rd_q,    skid_rd_d;
    logic          skid_rw_q,    skid_rw_d;

    logic [31:0]   retired_q, retired_d;

    logic [W-1:0]  b_sel;
    logic [W-1:0]  alu_res;
    logic          alu_zero;
    logic          in_fire;
    logic          out_fire;

    // In_Ready comes straight from the skid occupancy flop, so it never
    // depends combinationally on Out_Ready.
    assign In_Ready = !skid_valid_q;
    assign in_fire  = In_Valid && In_Ready;
    assign out_fire = out_valid_q && Out_Ready;

    // Operand select and ALU; zero flag is derived from the final result
    always_comb begin
        b_sel = ALUsrc ? Imm : B;
        case (Op)
            OP_ADD:  alu_res = A + b_sel;
            OP_SUB:  alu_res = A - b_sel;
            OP_AND:  alu_res = A & b_sel;
            OP_OR:   alu_res = A | b_sel;
            OP_NOT:  alu_res = ~A;
            OP_SRA:  alu_res = {A[W-1], A[W-1:1]};
            OP_SLL:  alu_res = {A[W-2:0], 1'b0};
            OP_SRL:  alu_res = {1'b0, A[W-1:1]};
            OP_ROL:  alu_res = {A[W-2:0], A[W-1]};
            OP_ROR:  alu_res = {A[0], A[W-1:1]};
            default: alu_res = A + b_sel;
        endcase
        alu_zero = (alu_res == '0);
    end

    // Next-state for output register, skid entry and retire counter
    always_comb begin
        out_valid_d  = out_valid_q;
        out_res_d    = out_res_q;
        out_zero_d   = out_zero_q;
        out_rd_d     = out_rd_q;
        out_rw_d     = out_rw_q;
        skid_valid_d = skid_valid_q;
        skid_res_d   = skid_res_q;
        skid_zero_d  = skid_zero_q;
        skid_rd_d    = skid_rd_q;
        skid_rw_d    = skid_rw_q;
        retired_d    = out_fire ? retired_q + 32'd1 : retired_q;

        if (Flush) begin
            // Drop everything held plus whatever is presented this cycle
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_fire) begin
            // Output slot frees up: oldest op (skid first) refills it
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_res_d    = skid_res_q;
                out_zero_d   = skid_zero_q;
                out_rd_d     = skid_rd_q;
                out_rw_d     = skid_rw_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_valid_d = 1'b1;
                out_res_d   = alu_res;
                out_zero_d  = alu_zero;
                out_rd_d    = Rd;
                out_rw_d    = RegWrite;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            // Output stalled: park the new op in the skid entry
            skid_valid_d = 1'b1;
            skid_res_d   = alu_res;
            skid_zero_d  = alu_zero;
            skid_rd_d    = Rd;
            skid_rw_d    = RegWrite;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_valid_q  <= 1'b0;
            out_res_q    <= '0;
            out_zero_q   <= 1'b0;
            out_rd_q     <= '0;
            out_rw_q     <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_res_q   <= '0;
            skid_zero_q  <= 1'b0;
            skid_rd_q    <= '0;
            skid_rw_q    <= 1'b0;
            retired_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_res_q    <= out_res_d;
            out_zero_q   <= out_zero_d;
            out_rd_q     <= out_rd_d;
            out_rw_q     <= out_rw_d;
            skid_valid_q <= skid_valid_d;
            skid_res_q   <= skid_res_d;
            skid_zero_q  <= skid_zero_d;
            skid_rd_q    <= skid_rd_d;
            skid_rw_q    <= skid_rw_d;
            retired_q    <= retired_d;
        end
    end

    assign Out_Valid    = out_valid_q;
    assign Out_Res      = out_res_q;
    assign Out_Zero     = out_zero_q;
    assign Out_Rd       = out_rd_q;
    assign Out_RegWrite = out_rw_q;
    assign Retired      = retired_q;

endmodule

// File: tb/tb_exec_stage.sv
// tb/tb_exec_stage.sv - directed self-checking bench for exec_stage
module tb_exec_stage;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        In_Valid;
    logic        In_Ready;
    logic [31:0] A, B, Imm;
    logic        ALUsrc;
    logic [3:0]  Op;
    logic [4:0]  Rd;
    logic        RegWrite;
    logic        Flush;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Out_Res;
    logic        Out_Zero;
    logic [4:0]  Out_Rd;
    logic        Out_RegWrite;
    logic [31:0] Retired;

    int n_cmp = 0;
    int n_err = 0;

    exec_stage #(.W(32), .RA(5)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .A(A), .B(B), .Imm(Imm), .ALUsrc(ALUsrc), .Op(Op), .Rd(Rd),
        .RegWrite(RegWrite), .Flush(Flush), .Out_Valid(Out_Valid),
        .Out_Ready(Out_Ready), .Out_Res(Out_Res), .Out_Zero(Out_Zero),
        .Out_Rd(Out_Rd), .Out_RegWrite(Out_RegWrite), .Retired(Retired)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic src, input logic [3:0] op, input logic [4:0] rd);
        In_Valid = 1'b1;
        A        = a;
        B        = b;
        Imm      = imm;
        ALUsrc   = src;
        Op       = op;
        Rd       = rd;
        RegWrite = 1'b1;
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    logic [3:0]  sh_op  [6];
    logic [31:0] sh_a   [6];
    logic [31:0] sh_exp [6];

    initial begin
        sh_op[0] = 4'b1000; sh_a[0] = 32'h8000_0001; sh_exp[0] = 32'hC000_0000;
        sh_op[1] = 4'b1010; sh_a[1] = 32'h8000_0001; sh_exp[1] = 32'h4000_0000;
        sh_op[2] = 4'b1001; sh_a[2] = 32'h8000_0001; sh_exp[2] = 32'h0000_0002;
        sh_op[3] = 4'b1100; sh_a[3] = 32'h8000_0001; sh_exp[3] = 32'h0000_0003;
        sh_op[4] = 4'b1101; sh_a[4] = 32'h8000_0001; sh_exp[4] = 32'hC000_0000;
        sh_op[5] = 4'b0111; sh_a[5] = 32'h0000_0001; sh_exp[5] = 32'h0000_0002;

        Rst_n = 1'b0; In_Valid = 1'b0; A = '0; B = '0; Imm = '0; ALUsrc = 1'b0;
        Op = '0; Rd = '0; RegWrite = 1'b0; Flush = 1'b0; Out_Ready = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_out_valid", {31'd0, Out_Valid}, 32'd0);
        chk("rst_out_res", Out_Res, 32'd0);
        chk("rst_out_zero", {31'd0, Out_Zero}, 32'd0);
        chk("rst_out_rd", {27'd0, Out_Rd}, 32'd0);
        chk("rst_out_rw", {31'd0, Out_RegWrite}, 32'd0);
        chk("rst_retired", Retired, 32'd0);
        Rst_n = 1'b1;
        tick();
        chk("rst_in_ready", {31'd0, In_Ready}, 32'd1);

        // Arithmetic: subtract via register and via immediate
        Out_Ready = 1'b1;
        issue(32'd7, 32'd5, 32'd0, 1'b0, 4'b0001, 5'd4);
        tick();
        chk("sub_valid", {31'd0, Out_Valid}, 32'd1);
        chk("sub_res", Out_Res, 32'd2);
        chk("sub_zero", {31'd0, Out_Zero}, 32'd0);
        chk("sub_rd", {27'd0, Out_Rd}, 32'd4);
        chk("sub_rw", {31'd0, Out_RegWrite}, 32'd1);
        issue(32'd5, 32'd99, 32'd5, 1'b1, 4'b0001, 5'd6);
        tick();
        chk("subi_res", Out_Res, 32'd0);
        chk("subi_zero", {31'd0, Out_Zero}, 32'd1);
        chk("subi_retired", Retired, 32'd1);

        // Shifts, rotates and the add fallback for an unused encoding
        for (int i = 0; i < 6; i++) begin
            issue(sh_a[i], 32'd1, 32'd0, 1'b0, sh_op[i], 5'(i + 8));
            tick();
            chk($sformatf("shift_op%b_res", sh_op[i]), Out_Res, sh_exp[i]);
            chk($sformatf("shift_op%b_rd", sh_op[i]), {27'd0, Out_Rd}, 32'(i + 8));
        end
        In_Valid = 1'b0;
        tick();
        chk("drain_valid", {31'd0, Out_Valid}, 32'd0);
        chk("drain_retired", Retired, 32'd8);

        // Backpressure: three back-to-back ops with the output stalled
        Out_Ready = 1'b0;
        issue(32'd10, 32'd1, 32'd0, 1'b0, 4'b0000, 5'd1);
        tick();
        chk("bp_in_ready_1", {31'd0, In_Ready}, 32'd1);
        issue(32'd20, 32'd1, 32'd0, 1'b0, 4'b0000, 5'd2);
        tick();
        chk("bp_in_ready_2", {31'd0, In_Ready}, 32'd0);
        chk("bp_hold_rd_a", {27'd0, Out_Rd}, 32'd1);
        issue(32'd30, 32'd1, 32'd0, 1'b0, 4'b0000, 5'd3);
        tick();
        chk("bp_hold_rd_b", {27'd0, Out_Rd}, 32'd1);
        chk("bp_hold_res", Out_Res, 32'd11);
        chk("bp_hold_valid", {31'd0, Out_Valid}, 32'd1);
        chk("bp_in_ready_3", {31'd0, In_Ready}, 32'd0);
        Out_Ready = 1'b1;
        tick();
        chk("bp_out2_rd", {27'd0, Out_Rd}, 32'd2);
        chk("bp_out2_res", Out_Res, 32'd21);
        chk("bp_in_ready_up", {31'd0, In_Ready}, 32'd1);
        chk("bp_retired_9", Retired, 32'd9);
        tick();
        In_Valid = 1'b0;
        chk("bp_out3_rd", {27'd0, Out_Rd}, 32'd3);
        chk("bp_out3_res", Out_Res, 32'd31);
        tick();
        chk("bp_empty", {31'd0, Out_Valid}, 32'd0);
        chk("bp_retired_11", Retired, 32'd11);

        // Flush with two buffered ops and a third presented
        Out_Ready = 1'b0;
        issue(32'd50, 32'd0, 32'd0, 1'b0, 4'b0000, 5'd5);
        tick();
        issue(32'd60, 32'd0, 32'd0, 1'b0, 4'b0000, 5'd6);
        tick();
        issue(32'd70, 32'd0, 32'd0, 1'b0, 4'b0000, 5'd7);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        In_Valid = 1'b0;
        chk("fl_out_valid", {31'd0, Out_Valid}, 32'd0);
        chk("fl_in_ready", {31'd0, In_Ready}, 32'd1);
        chk("fl_retired", Retired, 32'd11);
        Out_Ready = 1'b1;
        tick(); tick();
        chk("fl_no_emit", {31'd0, Out_Valid}, 32'd0);
        chk("fl_retired_after", Retired, 32'd11);

        // Counter wrap
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        #1;
        chk("wrap_preset", Retired, 32'hFFFF_FFFF);
        issue(32'd1, 32'd2, 32'd0, 1'b0, 4'b0000, 5'd9);
        tick();
        In_Valid = 1'b0;
        chk("wrap_res", Out_Res, 32'd3);
        tick();
        chk("wrap_retired", Retired, 32'd0);

        // Asynchronous reset mid-cycle while a result is held
        issue(32'd4, 32'd4, 32'd0, 1'b0, 4'b0000, 5'd12);
        tick();
        In_Valid = 1'b0;
        tick();
        issue(32'd9, 32'd0, 32'd0, 1'b0, 4'b0000, 5'd13);
        tick();
        In_Valid = 1'b0;
        chk("arst_pre_valid", {31'd0, Out_Valid}, 32'd1);
        chk("arst_pre_retired", Retired, 32'd1);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, Out_Valid}, 32'd0);
        chk("arst_retired", Retired, 32'd0);
        chk("arst_res", Out_Res, 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        tick();
        chk("arst_in_ready", {31'd0, In_Ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- Execute pipeline stage that sits directly upstream of the writeback/register-file write port.
- Accepts decoded operands from the decode stage and selects the B operand (register or immediate).
- Performs the 32-bit ALU operation and registers the result, Zero flag and destination tag behind a valid/ready handshake with a 2-entry skid buffer.
- Also flushes on branch mispredict and counts retired operations.

Parameters:
- W, 32, datapath width.
- RA, 5, register address width.

Ports:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  asynchronous active-low reset.
- In_Valid  in  1  upstream has an operation.
- In_Ready  out  1  stage can accept an operation this cycle.
- A  in  W  operand A (register file read port 1).
- B  in  W  operand B (register file read port 2).
- Imm  in  W  sign-extended immediate.
- ALUsrc  in  1  0 selects B, 1 selects Imm.
- Op  in  4  ALU function.
- Rd  in  RA  destination register.
- RegWrite  in  1  result is to be written back.
- Flush  in  1  discard all held and incoming operations.
- Out_Valid  out  1  result available.
- Out_Ready  in  1  downstream accepts the result.
- Out_Res  out  W  ALU result.
- Out_Zero  out  1  1 when Out_Res == 0.
- Out_Rd  out  RA  destination register.
- Out_RegWrite  out  1  write-back enable.
- Retired  out  32  count of results handed downstream.

Behaviour:
- Reset (Rst_n low, asynchronous): Out_Valid=0, skid entry empty, Out_Res=0, Out_Zero=0, Out_Rd=0, Out_RegWrite=0, Retired=0, In_Ready=1 after release.
- Operand select: Bsel = ALUsrc ? Imm : B.
- Op encoding, all signed two's complement, wrap on overflow:
  - 0000 add A+Bsel; 0001 sub A-Bsel; 0010 and; 0011 or; 0100 not A.
  - 1000 arithmetic shift right by 1 ({A[W-1],A[W-1:1]}); 1010 logical shift right by 1; 1001 shift left by 1.
  - 1100 rotate left by 1 ({A[W-2:0],A[W-1]}); 1101 rotate right by 1 ({A[0],A[W-1:1]}).
  - Any other encoding: add.
- Zero is computed from the final result of the selected op and travels with it.
- Transfer in: In_Valid & In_Ready at a rising edge. Transfer out: Out_Valid & Out_Ready at a rising edge.
- Latency: an accepted operation appears on Out_* the next cycle when the output register is empty or draining.
- Output register (stage 0) and skid entry (stage 1):
  - In_Ready = !skid_full; it is registered and does not depend combinationally on Out_Ready.
  - Accept while the output holds data and Out_Ready=0: the new op goes to the skid; In_Ready drops next cycle.
  - Out_Ready=1 with the skid full: skid moves to output; In_Ready rises next cycle.
  - Output empty or draining and no skid: the new op loads the output directly.
  - Simultaneous accept and drain with the skid full cannot occur because In_Ready=0.
- Out_* hold stable while Out_Valid=1 and Out_Ready=0.
- Order is strictly preserved: FIFO depth 2, never reordered, never dropped.
- Flush (synchronous, highest priority): next cycle Out_Valid=0, skid empty, In_Ready=1; any op presented in the flush cycle is discarded. Retired does not count flushed ops.
- Retired increments by 1 on each output transfer and wraps from 2^32-1 to 0.
- Reset asserted mid-operation clears everything immediately, regardless of Clk.

Test Plan:
- Reset: assert Rst_n=0 mid-cycle with Out_Valid=1 -> Out_Valid=0, Retired=0 immediately; In_Ready=1 after release.
- Arithmetic: A=7, B=5, ALUsrc=0, Op=0001, Out_Ready=1 -> next cycle Out_Res=2, Zero=0. Then A=5, Imm=5, ALUsrc=1, Op=0001 -> Out_Res=0, Zero=1.
- Shifts and rotates with A=0x80000001:
  - Op 1000 -> 0xC0000000
  - Op 1010 -> 0x40000000
  - Op 1001 -> 0x00000002
  - Op 1100 -> 0x00000003
  - Op 1101 -> 0xC0000000
  - Op 0111 with A=B=1 -> 2
- Backpressure: Out_Ready=0, issue 3 back-to-back ops (Rd=1,2,3) -> only 1 and 2 accepted, In_Ready=0 from the cycle after the second. Raise Out_Ready -> Rd 1,2,3 emerge in order, held stable while stalled, Retired=3.
- Flush: two ops buffered and a third presented with Flush=1 -> next cycle Out_Valid=0, In_Ready=1, Retired unchanged, no buffered op ever emitted.
- Counter wrap: force Retired to 0xFFFFFFFF and complete one transfer -> Retired=0.
